// File: rtl/pong_frame_sched.sv
// Pong game-flow scheduler: serve/play/point/over sequencing and per-frame datapath phase strobes.
// Optional pause support is compiled in with the PONG_PAUSE_EN macro.
module pong_frame_sched #(
    parameter int unsigned FRAME_DIV    = 2,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 30,
    parameter int unsigned WIN_SCORE    = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       paddle_step,
    output logic       ai_step,
    output logic       ball_step,
    output logic       collide_eval,
    output logic       ball_center,
    output logic       serve_dir,
    output logic [3:0] score_p,
    output logic [3:0] score_o,
    output logic [2:0] state,
    output logic       busy
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned PHASE_W = 2;

    localparam logic [CNT_W-1:0]   FRAME_LAST = CNT_W'(FRAME_DIV - 1);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4,
        PAUSE = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic                 busy_q, busy_d;
    logic                 paddle_step_q, paddle_step_d;
    logic                 ai_step_q, ai_step_d;
    logic                 ball_step_q, ball_step_d;
    logic                 collide_eval_q, collide_eval_d;
    logic                 ball_center_q, ball_center_d;
    logic                 serve_dir_q, serve_dir_d;
    logic [SCORE_W-1:0]   score_p_q, score_p_d;
    logic [SCORE_W-1:0]   score_o_q, score_o_d;
    logic                 miss_l_q, miss_l_d;
    logic                 miss_r_q, miss_r_d;
    logic                 pause_rise_c;

`ifdef PONG_PAUSE_EN
    logic pause_q, pause_d;

    // Registered edge detect on the pause button
    assign pause_d      = pause_btn;
    assign pause_rise_c = pause_btn & ~pause_q;

    always_ff @(posedge clk) begin
        if (rst) pause_q <= 1'b0;
        else     pause_q <= pause_d;
    end
`else
    logic unused_pause;

    assign unused_pause = pause_btn;
    assign pause_rise_c = 1'b0;
`endif

    // Saturating score increment, capped at the winning score
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= WIN) ? WIN : s + SCORE_W'(1);
    endfunction

    always_comb begin
        state_d        = state_q;
        frame_cnt_d    = frame_cnt_q;
        phase_d        = phase_q;
        busy_d         = busy_q;
        paddle_step_d  = 1'b0;
        ai_step_d      = 1'b0;
        ball_step_d    = 1'b0;
        collide_eval_d = 1'b0;
        ball_center_d  = 1'b0;
        serve_dir_d    = serve_dir_q;
        score_p_d      = score_p_q;
        score_o_d      = score_o_q;
        miss_l_d       = miss_l_q;
        miss_r_d       = miss_r_q;

        case (state_q)
            IDLE: begin
                if (start_btn) begin
                    state_d       = SERVE;
                    frame_cnt_d   = '0;
                    score_p_d     = '0;
                    score_o_d     = '0;
                    serve_dir_d   = 1'b1;
                    ball_center_d = 1'b1;
                end
            end

            SERVE: begin
                if (frame_tick) begin
                    if (frame_cnt_q == SERVE_LAST) begin
                        state_d     = PLAY;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end
                end
            end

            PLAY: begin
                if (busy_q) begin
                    // Update sequence S0..S3; ticks and pause edges are dropped while busy
                    case (phase_q)
                        2'd0: begin
                            phase_d     = 2'd1;
                            ball_step_d = 1'b1;
                        end
                        2'd1: begin
                            phase_d        = 2'd2;
                            collide_eval_d = 1'b1;
                        end
                        2'd2: begin
                            phase_d  = 2'd3;
                            miss_l_d = miss_left;
                            miss_r_d = miss_right;
                        end
                        default: begin
                            phase_d = 2'd0;
                            busy_d  = 1'b0;
                            if (miss_l_q || miss_r_q) begin
                                state_d     = POINT;
                                frame_cnt_d = '0;
                            end
                            if (miss_l_q && !miss_r_q) begin
                                score_p_d   = sat_inc(score_p_q);
                                serve_dir_d = 1'b0;
                            end else if (miss_r_q && !miss_l_q) begin
                                score_o_d   = sat_inc(score_o_q);
                                serve_dir_d = 1'b1;
                            end else if (miss_l_q && miss_r_q) begin
                                serve_dir_d = ~serve_dir_q;
                            end
                        end
                    endcase
                end else if (pause_rise_c) begin
                    // Frame counter deliberately kept across the pause
                    state_d = PAUSE;
                end else if (frame_tick) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d   = '0;
                        busy_d        = 1'b1;
                        phase_d       = 2'd0;
                        paddle_step_d = 1'b1;
                        ai_step_d     = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end
                end
            end

            POINT: begin
                if (frame_tick) begin
                    if (frame_cnt_q == POINT_LAST) begin
                        frame_cnt_d   = '0;
                        ball_center_d = 1'b1;
                        state_d       = ((score_p_q == WIN) || (score_o_q == WIN)) ? OVER : SERVE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end
                end
            end

            OVER: begin
                if (start_btn) begin
                    state_d     = IDLE;
                    frame_cnt_d = '0;
                end
            end

            PAUSE: begin
                if (pause_rise_c) state_d = PLAY;
            end

            default: begin
                state_d     = IDLE;
                frame_cnt_d = '0;
                busy_d      = 1'b0;
                phase_d     = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            frame_cnt_q    <= '0;
            phase_q        <= '0;
            busy_q         <= 1'b0;
            paddle_step_q  <= 1'b0;
            ai_step_q      <= 1'b0;
            ball_step_q    <= 1'b0;
            collide_eval_q <= 1'b0;
            ball_center_q  <= 1'b0;
            serve_dir_q    <= 1'b1;
            score_p_q      <= '0;
            score_o_q      <= '0;
            miss_l_q       <= 1'b0;
            miss_r_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            phase_q        <= phase_d;
            busy_q         <= busy_d;
            paddle_step_q  <= paddle_step_d;
            ai_step_q      <= ai_step_d;
            ball_step_q    <= ball_step_d;
            collide_eval_q <= collide_eval_d;
            ball_center_q  <= ball_center_d;
            serve_dir_q    <= serve_dir_d;
            score_p_q      <= score_p_d;
            score_o_q      <= score_o_d;
            miss_l_q       <= miss_l_d;
            miss_r_q       <= miss_r_d;
        end
    end

    assign paddle_step  = paddle_step_q;
    assign ai_step      = ai_step_q;
    assign ball_step    = ball_step_q;
    assign collide_eval = collide_eval_q;
    assign ball_center  = ball_center_q;
    assign serve_dir    = serve_dir_q;
    assign score_p      = score_p_q;
    assign score_o      = score_o_q;
    assign state        = state_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_pong_frame_sched.sv
// Directed self-checking bench for pong_frame_sched (default parameters).
module tb_pong_frame_sched;

    logic       clk = 1'b0;
    logic       rst, frame_tick, start_btn, pause_btn, miss_left, miss_right;
    logic       paddle_step, ai_step, ball_step, collide_eval, ball_center, serve_dir, busy;
    logic [3:0] score_p, score_o;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;
    int n_paddle = 0, n_ai = 0, n_ball = 0, n_collide = 0, n_center = 0, n_busy = 0;
    bit saw5 = 1'b0;

    pong_frame_sched dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
        .pause_btn(pause_btn), .miss_left(miss_left), .miss_right(miss_right),
        .paddle_step(paddle_step), .ai_step(ai_step), .ball_step(ball_step),
        .collide_eval(collide_eval), .ball_center(ball_center), .serve_dir(serve_dir),
        .score_p(score_p), .score_o(score_o), .state(state), .busy(busy)
    );

    always #5 clk = ~clk;

    // Per-cycle strobe counters, sampled on the falling edge
    always @(negedge clk) begin
        if (paddle_step === 1'b1)  n_paddle++;
        if (ai_step === 1'b1)      n_ai++;
        if (ball_step === 1'b1)    n_ball++;
        if (collide_eval === 1'b1) n_collide++;
        if (ball_center === 1'b1)  n_center++;
        if (busy === 1'b1)         n_busy++;
        if (state === 3'd5)        saw5 = 1'b1;
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc(5);
    endtask

    task automatic ticks(input int n);
        repeat (n) send_tick();
    endtask

    task automatic play_point(input logic l, input logic r);
        send_tick();
        miss_left  = l;
        miss_right = r;
        send_tick();
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_tick = 1'b0; start_btn = 1'b1; pause_btn = 1'b0;
        miss_left = 1'b0; miss_right = 1'b0;
        cyc(2);
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_cmp++; if ({score_p, score_o} !== 8'h00) begin n_err++; $display("FAIL reset_scores: got %0d/%0d expected 0/0", score_p, score_o); end
        n_cmp++; if (serve_dir !== 1'b1) begin n_err++; $display("FAIL reset_serve_dir: got %b expected 1", serve_dir); end
        n_cmp++; if ({paddle_step, ai_step, ball_step, collide_eval, ball_center, busy} !== 6'b0) begin
            n_err++; $display("FAIL reset_strobes: got %b expected 000000",
                              {paddle_step, ai_step, ball_step, collide_eval, ball_center, busy});
        end
        start_btn = 1'b0;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_start();
        int c0;
        c0 = n_center;
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL start_state: got %0d expected 1", state); end
        n_cmp++; if (ball_center !== 1'b1) begin n_err++; $display("FAIL start_center: got %b expected 1", ball_center); end
        ticks(59);
        n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL serve_hold: got %0d expected 1", state); end
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL serve_to_play: got %0d expected 2", state); end
        cyc(5);
        n_cmp++; if (n_center - c0 != 1) begin n_err++; $display("FAIL start_center_count: got %0d expected 1", n_center - c0); end
        n_cmp++; if ({score_p, score_o} !== 8'h00) begin n_err++; $display("FAIL start_scores: got %0d/%0d expected 0/0", score_p, score_o); end
    endtask

    task automatic test_update();
        int p0, a0, b0, c0, y0;
        p0 = n_paddle; a0 = n_ai; b0 = n_ball; c0 = n_collide; y0 = n_busy;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        n_cmp++; if ({paddle_step, busy} !== 2'b00) begin n_err++; $display("FAIL update_first_tick: got %b expected 00", {paddle_step, busy}); end
        cyc(3);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        n_cmp++; if ({paddle_step, ai_step, ball_step, collide_eval, busy} !== 5'b11001) begin
            n_err++; $display("FAIL update_s0: got %b expected 11001", {paddle_step, ai_step, ball_step, collide_eval, busy});
        end
        cyc();
        n_cmp++; if ({paddle_step, ai_step, ball_step, collide_eval, busy} !== 5'b00101) begin
            n_err++; $display("FAIL update_s1: got %b expected 00101", {paddle_step, ai_step, ball_step, collide_eval, busy});
        end
        cyc();
        n_cmp++; if ({paddle_step, ai_step, ball_step, collide_eval, busy} !== 5'b00011) begin
            n_err++; $display("FAIL update_s2: got %b expected 00011", {paddle_step, ai_step, ball_step, collide_eval, busy});
        end
        cyc();
        n_cmp++; if ({paddle_step, ai_step, ball_step, collide_eval, busy, state} !== 8'b00001_010) begin
            n_err++; $display("FAIL update_s3: got %b expected 00001010", {paddle_step, ai_step, ball_step, collide_eval, busy, state});
        end
        cyc();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL update_done: got busy=%b expected 0", busy); end
        cyc(2);
        ticks(2);
        n_cmp++; if ((n_paddle - p0 != 2) || (n_ai - a0 != 2) || (n_ball - b0 != 2) || (n_collide - c0 != 2)) begin
            n_err++; $display("FAIL update_counts: got %0d/%0d/%0d/%0d expected 2/2/2/2",
                              n_paddle - p0, n_ai - a0, n_ball - b0, n_collide - c0);
        end
        n_cmp++; if (n_busy - y0 != 8) begin n_err++; $display("FAIL update_busy_cycles: got %0d expected 8", n_busy - y0); end
    endtask

    task automatic test_tick_while_busy();
        send_tick();
        frame_tick = 1'b1;
        cyc();
        n_cmp++; if (paddle_step !== 1'b1) begin n_err++; $display("FAIL busy_seq_start: got %b expected 1", paddle_step); end
        cyc();
        frame_tick = 1'b0;
        cyc(5);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        n_cmp++; if (paddle_step !== 1'b0) begin n_err++; $display("FAIL busy_tick_ignored: got %b expected 0", paddle_step); end
        cyc(5);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        n_cmp++; if (paddle_step !== 1'b1) begin n_err++; $display("FAIL busy_next_seq: got %b expected 1", paddle_step); end
        cyc(5);
    endtask

    task automatic test_miss_left();
        play_point(1'b1, 1'b0);
        n_cmp++; if ({state, score_p, score_o, serve_dir} !== {3'd3, 4'd1, 4'd0, 1'b0}) begin
            n_err++; $display("FAIL miss_left: got st=%0d p=%0d o=%0d dir=%b expected st=3 p=1 o=0 dir=0",
                              state, score_p, score_o, serve_dir);
        end
        ticks(29);
        n_cmp++; if (state !== 3'd3) begin n_err++; $display("FAIL point_hold: got %0d expected 3", state); end
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        n_cmp++; if ({state, ball_center} !== {3'd1, 1'b1}) begin
            n_err++; $display("FAIL point_to_serve: got st=%0d center=%b expected st=1 center=1", state, ball_center);
        end
        cyc(5);
    endtask

    task automatic test_both_miss();
        ticks(60);
        n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL both_in_play: got %0d expected 2", state); end
        play_point(1'b1, 1'b1);
        n_cmp++; if ({state, score_p, score_o, serve_dir} !== {3'd3, 4'd1, 4'd0, 1'b1}) begin
            n_err++; $display("FAIL both_miss: got st=%0d p=%0d o=%0d dir=%b expected st=3 p=1 o=0 dir=1",
                              state, score_p, score_o, serve_dir);
        end
        ticks(30);
        n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL both_to_serve: got %0d expected 1", state); end
    endtask

    task automatic test_win();
        ticks(60);
        for (int i = 0; i < 8; i++) begin
            play_point(1'b0, 1'b1);
            ticks(30);
            ticks(60);
        end
        n_cmp++; if ({state, score_p, score_o} !== {3'd2, 4'd1, 4'd8}) begin
            n_err++; $display("FAIL win_pre: got st=%0d p=%0d o=%0d expected st=2 p=1 o=8", state, score_p, score_o);
        end
        play_point(1'b0, 1'b1);
        n_cmp++; if ({state, score_o, serve_dir} !== {3'd3, 4'd9, 1'b1}) begin
            n_err++; $display("FAIL win_point: got st=%0d o=%0d dir=%b expected st=3 o=9 dir=1", state, score_o, serve_dir);
        end
        ticks(29);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        n_cmp++; if ({state, ball_center} !== {3'd4, 1'b1}) begin
            n_err++; $display("FAIL win_over: got st=%0d center=%b expected st=4 center=1", state, ball_center);
        end
        cyc(5);
        ticks(3);
        n_cmp++; if ({state, score_p, score_o} !== {3'd4, 4'd1, 4'd9}) begin
            n_err++; $display("FAIL over_hold: got st=%0d p=%0d o=%0d expected st=4 p=1 o=9", state, score_p, score_o);
        end
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL over_to_idle: got %0d expected 0", state); end
        cyc(2);
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL idle_stays: got %0d expected 0", state); end
    endtask

    task automatic test_reset_mid();
        int k0;
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        n_cmp++; if ({score_p, score_o} !== 8'h00) begin n_err++; $display("FAIL restart_clear: got %0d/%0d expected 0/0", score_p, score_o); end
        ticks(60);
        send_tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        n_cmp++; if (ball_step !== 1'b1) begin n_err++; $display("FAIL mid_s1: got %b expected 1", ball_step); end
        k0 = n_collide;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++; if ({state, busy, paddle_step, ai_step, ball_step, collide_eval, ball_center, serve_dir} !== {3'd0, 7'b0000001}) begin
            n_err++; $display("FAIL mid_reset: got %b expected 0000000001",
                              {state, busy, paddle_step, ai_step, ball_step, collide_eval, ball_center, serve_dir});
        end
        cyc(4);
        n_cmp++; if ((n_collide != k0) || (state !== 3'd0)) begin
            n_err++; $display("FAIL mid_no_collide: got collides=%0d st=%0d expected 0 and 0", n_collide - k0, state);
        end
    endtask

`ifdef PONG_PAUSE_EN
    task automatic test_pause();
        int p0;
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        ticks(60);
        send_tick();
        pause_btn = 1'b1;
        cyc();
        n_cmp++; if (state !== 3'd5) begin n_err++; $display("FAIL pause_enter: got %0d expected 5", state); end
        p0 = n_paddle;
        ticks(10);
        n_cmp++; if ((n_paddle != p0) || (state !== 3'd5)) begin
            n_err++; $display("FAIL pause_quiet: got strobes=%0d st=%0d expected 0 and 5", n_paddle - p0, state);
        end
        pause_btn = 1'b0;
        cyc();
        pause_btn = 1'b1;
        cyc();
        pause_btn = 1'b0;
        n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL pause_exit: got %0d expected 2", state); end
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        n_cmp++; if (paddle_step !== 1'b1) begin n_err++; $display("FAIL pause_resume_count: got %b expected 1", paddle_step); end
        cyc(5);
    endtask
`else
    task automatic test_pause();
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        ticks(60);
        pause_btn = 1'b1;
        cyc();
        pause_btn = 1'b0;
        cyc();
        n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL nopause_state: got %0d expected 2", state); end
        n_cmp++; if (saw5 !== 1'b0) begin n_err++; $display("FAIL nopause_never5: got %b expected 0", saw5); end
    endtask
`endif

    initial begin
        test_reset();
        test_start();
        test_update();
        test_tick_while_busy();
        test_miss_left();
        test_both_miss();
        test_win();
        test_reset_mid();
        test_pause();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
